// File: rtl/instr_queue.sv
// instr_queue: dual-push / dual-pop instruction FIFO between fetch2 and decode.
// Entries are packed as {pc, instr, is_ret, is_call, bp_taken, bp_target}.
// The read side is a combinational view of the two oldest entries; every
// state change (push, pop, flush) takes effect on the rising clock edge.
module instr_queue #(
    parameter int DEPTH = 16,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              flush,
    input  logic [1:0]        push_valid,
    input  logic [1:0][31:0]  push_pc,
    input  logic [1:0][31:0]  push_instr,
    input  logic [1:0]        push_is_ret,
    input  logic [1:0]        push_is_call,
    input  logic              push_bp_taken,
    input  logic [31:0]       push_bp_target,
    output logic              queue_full,
    output logic [1:0]        out_valid,
    output logic [1:0][31:0]  out_pc,
    output logic [1:0][31:0]  out_instr,
    output logic [1:0]        out_is_ret,
    output logic [1:0]        out_is_call,
    output logic [1:0]        out_bp_taken,
    output logic [1:0][31:0]  out_bp_target,
    input  logic [1:0]        pop_cnt
);

    localparam int ENT_W = 99;
    localparam logic [PTR_W:0] FULL_TH = (PTR_W+1)'(DEPTH - 2);

    logic [ENT_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [PTR_W:0]   r_count;

    logic             w_full;
    logic             w_push_ok;
    logic [1:0]       w_push_num;
    logic [1:0]       w_pop_req;
    logic [1:0]       w_pop_eff;
    logic             w_we_tail;
    logic             w_we_next;
    logic [ENT_W-1:0] w_slot0;
    logic [ENT_W-1:0] w_slot1;
    logic [ENT_W-1:0] w_wdat_tail;
    logic [PTR_W-1:0] w_tail_p1;
    logic [PTR_W-1:0] w_head_p1;
    logic [ENT_W-1:0] w_rd0;
    logic [ENT_W-1:0] w_rd1;

    // Full when fewer than two entries are free; depends on count only.
    assign w_full     = (r_count > FULL_TH);
    assign queue_full = w_full;

    // A pair is accepted only with room for both slots and no flush pending.
    assign w_push_ok  = ~w_full & ~flush;
    assign w_push_num = w_push_ok ? ({1'b0, push_valid[0]} + {1'b0, push_valid[1]}) : 2'd0;

    // Entry images for each incoming slot; prediction info is shared by the pair.
    assign w_slot0 = {push_pc[0], push_instr[0], push_is_ret[0], push_is_call[0],
                      push_bp_taken, push_bp_target};
    assign w_slot1 = {push_pc[1], push_instr[1], push_is_ret[1], push_is_call[1],
                      push_bp_taken, push_bp_target};

    // Compaction: the lowest valid slot goes to tail, slot1 follows only for a full pair.
    assign w_wdat_tail = push_valid[0] ? w_slot0 : w_slot1;
    assign w_we_tail   = w_push_ok & (|push_valid);
    assign w_we_next   = w_push_ok & (&push_valid);
    assign w_tail_p1   = r_tail + PTR_W'(1);
    assign w_head_p1   = r_head + PTR_W'(1);

    // Clamp the pop request: 3 behaves as 2, and never more than the occupancy.
    always_comb begin
        w_pop_req = pop_cnt;
        w_pop_eff = pop_cnt;
        if (pop_cnt == 2'd3) begin
            w_pop_req = 2'd2;
        end else begin
            w_pop_req = pop_cnt;
        end
        if ((PTR_W+1)'(w_pop_req) > r_count) begin
            w_pop_eff = r_count[1:0];
        end else begin
            w_pop_eff = w_pop_req;
        end
    end

    // Pointer and occupancy update; flush empties the queue and drops the same-cycle push/pop.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_head  <= {PTR_W{1'b0}};
            r_tail  <= {PTR_W{1'b0}};
            r_count <= {(PTR_W+1){1'b0}};
        end else if (flush) begin
            r_head  <= {PTR_W{1'b0}};
            r_tail  <= {PTR_W{1'b0}};
            r_count <= {(PTR_W+1){1'b0}};
        end else begin
            r_head  <= r_head + PTR_W'(w_pop_eff);
            r_tail  <= r_tail + PTR_W'(w_push_num);
            r_count <= r_count + (PTR_W+1)'(w_push_num) - (PTR_W+1)'(w_pop_eff);
        end
    end

    // Entry storage; contents are qualified by count so they need no reset.
    always_ff @(posedge clk) begin
        if (w_we_tail) begin
            r_mem[r_tail] <= w_wdat_tail;
        end
        if (w_we_next) begin
            r_mem[w_tail_p1] <= w_slot1;
        end
    end

    // Read view of head and head+1; invalid slots are forced to zero.
    always_comb begin
        out_valid[0] = (r_count != {(PTR_W+1){1'b0}});
        out_valid[1] = (r_count > (PTR_W+1)'(1));
        if (out_valid[0]) begin
            w_rd0 = r_mem[r_head];
        end else begin
            w_rd0 = {ENT_W{1'b0}};
        end
        if (out_valid[1]) begin
            w_rd1 = r_mem[w_head_p1];
        end else begin
            w_rd1 = {ENT_W{1'b0}};
        end
    end

    assign out_pc[0]        = w_rd0[98:67];
    assign out_instr[0]     = w_rd0[66:35];
    assign out_is_ret[0]    = w_rd0[34];
    assign out_is_call[0]   = w_rd0[33];
    assign out_bp_taken[0]  = w_rd0[32];
    assign out_bp_target[0] = w_rd0[31:0];
    assign out_pc[1]        = w_rd1[98:67];
    assign out_instr[1]     = w_rd1[66:35];
    assign out_is_ret[1]    = w_rd1[34];
    assign out_is_call[1]   = w_rd1[33];
    assign out_bp_taken[1]  = w_rd1[32];
    assign out_bp_target[1] = w_rd1[31:0];

endmodule

// File: tb/tb_instr_queue.sv
// Bench for instr_queue: directed scenarios followed by random traffic, all
// checked against a queue-based reference model of the FIFO behaviour.
module tb_instr_queue;

    localparam int DEPTH = 16;

    logic              clk;
    logic              resetn;
    logic              flush;
    logic [1:0]        push_valid;
    logic [1:0][31:0]  push_pc;
    logic [1:0][31:0]  push_instr;
    logic [1:0]        push_is_ret;
    logic [1:0]        push_is_call;
    logic              push_bp_taken;
    logic [31:0]       push_bp_target;
    logic              queue_full;
    logic [1:0]        out_valid;
    logic [1:0][31:0]  out_pc;
    logic [1:0][31:0]  out_instr;
    logic [1:0]        out_is_ret;
    logic [1:0]        out_is_call;
    logic [1:0]        out_bp_taken;
    logic [1:0][31:0]  out_bp_target;
    logic [1:0]        pop_cnt;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        ret;
        logic        call;
        logic        bpt;
        logic [31:0] tgt;
    } ent_t;

    ent_t q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    instr_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .resetn(resetn), .flush(flush),
        .push_valid(push_valid), .push_pc(push_pc), .push_instr(push_instr),
        .push_is_ret(push_is_ret), .push_is_call(push_is_call),
        .push_bp_taken(push_bp_taken), .push_bp_target(push_bp_target),
        .queue_full(queue_full), .out_valid(out_valid), .out_pc(out_pc),
        .out_instr(out_instr), .out_is_ret(out_is_ret), .out_is_call(out_is_call),
        .out_bp_taken(out_bp_taken), .out_bp_target(out_bp_target),
        .pop_cnt(pop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Compare every output against the model's two oldest entries.
    task automatic check_all();
        ent_t e;
        chk("queue_full", 32'(queue_full), 32'(q.size() > DEPTH - 2));
        for (int s = 0; s < 2; s++) begin
            if (q.size() > s) e = q[s];
            else e = '{pc: 32'd0, instr: 32'd0, ret: 1'b0, call: 1'b0, bpt: 1'b0, tgt: 32'd0};
            chk($sformatf("out_valid[%0d]", s), 32'(out_valid[s]), 32'(q.size() > s));
            chk($sformatf("out_pc[%0d]", s), out_pc[s], e.pc);
            chk($sformatf("out_instr[%0d]", s), out_instr[s], e.instr);
            chk($sformatf("out_is_ret[%0d]", s), 32'(out_is_ret[s]), 32'(e.ret));
            chk($sformatf("out_is_call[%0d]", s), 32'(out_is_call[s]), 32'(e.call));
            chk($sformatf("out_bp_taken[%0d]", s), 32'(out_bp_taken[s]), 32'(e.bpt));
            chk($sformatf("out_bp_target[%0d]", s), out_bp_target[s], e.tgt);
        end
    endtask

    // Drive a push pair with random payload around the given PCs.
    task automatic set_push(input logic [1:0] pv, input logic [31:0] pc0, input logic [31:0] pc1);
        push_valid     = pv;
        push_pc[0]     = pc0;
        push_pc[1]     = pc1;
        push_instr[0]  = $urandom;
        push_instr[1]  = $urandom;
        push_is_ret    = 2'($urandom_range(0, 3));
        push_is_call   = 2'($urandom_range(0, 3));
        push_bp_taken  = 1'($urandom_range(0, 1));
        push_bp_target = $urandom;
    endtask

    // Apply the model's rules to the current inputs, clock once, then compare.
    task automatic tick();
        bit   full;
        int   p;
        ent_t e;
        full = (q.size() > DEPTH - 2);
        if (flush) begin
            q.delete();
        end else begin
            p = (pop_cnt == 2'd3) ? 2 : int'(pop_cnt);
            if (p > q.size()) p = q.size();
            repeat (p) void'(q.pop_front());
            if (!full) begin
                for (int s = 0; s < 2; s++) begin
                    if (push_valid[s]) begin
                        e.pc = push_pc[s]; e.instr = push_instr[s];
                        e.ret = push_is_ret[s]; e.call = push_is_call[s];
                        e.bpt = push_bp_taken; e.tgt = push_bp_target;
                        q.push_back(e);
                    end
                end
            end
        end
        @(posedge clk);
        #1;
        check_all();
        push_valid = 2'b00;
        pop_cnt    = 2'd0;
        flush      = 1'b0;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        #1;
        check_all();
    endtask

    initial begin
        resetn = 1'b0; flush = 1'b0; pop_cnt = 2'd0;
        set_push(2'b00, 32'd0, 32'd0);
        #1;
        chk("reset_valid", 32'(out_valid), 32'd0);
        chk("reset_full", 32'(queue_full), 32'd0);
        do_reset();

        // Build count=5, then assert reset asynchronously mid-cycle.
        set_push(2'b11, 32'h1000, 32'h1004); tick();
        set_push(2'b11, 32'h1008, 32'h100C); tick();
        set_push(2'b01, 32'h1010, 32'h1014); tick();
        chk("pre_reset_valid", 32'(out_valid), 32'd3);
        #2;
        resetn = 1'b0;
        #1;
        q.delete();
        chk("async_reset_valid", 32'(out_valid), 32'd0);
        chk("async_reset_full", 32'(queue_full), 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        set_push(2'b11, 32'hBFC00000, 32'hBFC00004); tick();
        chk("boot_valid", 32'(out_valid), 32'd3);
        chk("boot_pc0", out_pc[0], 32'hBFC00000);
        chk("boot_pc1", out_pc[1], 32'hBFC00004);

        // Flush priority over simultaneous push and pop at count=6.
        set_push(2'b11, 32'h2000, 32'h2004); tick();
        set_push(2'b11, 32'h2008, 32'h200C); tick();
        set_push(2'b11, 32'h2010, 32'h2014); flush = 1'b1; pop_cnt = 2'd1; tick();
        chk("flush_valid", 32'(out_valid), 32'd0);
        chk("flush_full", 32'(queue_full), 32'd0);

        // Compaction: slot1 alone lands at the head.
        set_push(2'b10, 32'h80000000, 32'h80000004);
        push_bp_taken = 1'b1; push_bp_target = 32'h80000100; tick();
        chk("compact_valid", 32'(out_valid), 32'd1);
        chk("compact_pc0", out_pc[0], 32'h80000004);
        chk("compact_bpt0", 32'(out_bp_taken[0]), 32'd1);
        chk("compact_tgt0", out_bp_target[0], 32'h80000100);
        pop_cnt = 2'd3; tick();

        // Fill to full, try an ignored push, then pop to release.
        for (int i = 0; i < 7; i++) begin
            set_push(2'b11, 32'h3000 + 32'(8 * i), 32'h3004 + 32'(8 * i)); tick();
        end
        chk("fill14_full", 32'(queue_full), 32'd0);
        set_push(2'b11, 32'h3100, 32'h3104); tick();
        chk("fill16_full", 32'(queue_full), 32'd1);
        set_push(2'b11, 32'h3200, 32'h3204); tick();
        chk("ignored_full", 32'(queue_full), 32'd1);
        pop_cnt = 2'd2; tick();
        chk("popped_full", 32'(queue_full), 32'd0);
        for (int i = 0; i < 7; i++) begin
            pop_cnt = 2'd2; tick();
        end
        chk("drained_valid", 32'(out_valid), 32'd0);

        // Wrap-around: move both pointers to DEPTH-1, then push a pair across the end.
        do_reset();
        for (int i = 0; i < DEPTH - 1; i++) begin
            set_push(2'b01, 32'h4000 + 32'(4 * i), 32'h0); tick();
            pop_cnt = 2'd1; tick();
        end
        set_push(2'b11, 32'h5000, 32'h5004); tick();
        chk("wrap_pc0", out_pc[0], 32'h5000);
        chk("wrap_pc1", out_pc[1], 32'h5004);
        pop_cnt = 2'd1; tick();
        chk("wrap_after_pop_pc0", out_pc[0], 32'h5004);
        pop_cnt = 2'd2; tick();
        chk("clamp_valid", 32'(out_valid), 32'd0);

        // Simultaneous push of a pair and pop of two at count=3.
        set_push(2'b11, 32'h6000, 32'h6004); tick();
        set_push(2'b01, 32'h6008, 32'h0); tick();
        set_push(2'b11, 32'h600C, 32'h6010); pop_cnt = 2'd2; tick();
        chk("simul_valid", 32'(out_valid), 32'd3);
        chk("simul_pc0", out_pc[0], 32'h6008);
        chk("simul_pc1", out_pc[1], 32'h600C);
        pop_cnt = 2'd1; tick();
        chk("simul_next_pc1", out_pc[1], 32'h6010);

        // Random traffic, biased toward pushing so the full boundary is exercised.
        for (int i = 0; i < 800; i++) begin
            set_push(2'($urandom_range(0, 3)), $urandom, $urandom);
            pop_cnt = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : 2'($urandom_range(0, 1));
            flush   = ($urandom_range(0, 59) == 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_queue.md
Name: instr_queue

Overview:
- Dual-push, dual-pop instruction FIFO between fetch2 and decode/issue.
- Write side: accepts up to two fetched instructions per cycle with PC, is_ret/is_call flags and branch-prediction info; drives queue_full back to fetch2.
- Read side: presents the two oldest entries to decode; decode pops 0, 1 or 2 per cycle.
- Cleared in one cycle by pipeline flush (branch mispredict, eret, cp0 flush).

Parameters:
- DEPTH, 16, number of entries; power of two, at least 4.
- PTR_W, $clog2(DEPTH), read/write pointer width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- flush  in  1  discard all entries; highest priority.
- push_valid  in  2  per-slot write valid; bit0 = slot0 (PC), bit1 = slot1 (PC+4).
- push_pc  in  2x32  slot PCs.
- push_instr  in  2x32  slot instruction words.
- push_is_ret  in  2  per-slot return predecode flag.
- push_is_call  in  2  per-slot call predecode flag.
- push_bp_taken  in  1  pair's predicted-taken flag, copied into every entry written this cycle.
- push_bp_target  in  32  pair's predicted PC, copied likewise.
- queue_full  out  1  fewer than 2 free entries; writes are ignored while high.
- out_valid  out  2  bit0 = head entry valid; bit1 = head+1 valid.
- out_pc, out_instr  out  2x32 each  head and head+1 contents.
- out_is_ret, out_is_call, out_bp_taken  out  2 each  head and head+1 flags.
- out_bp_target  out  2x32  head and head+1 predicted PC.
- pop_cnt  in  2  entries consumed this cycle, 0..2.

Behaviour:
- Storage: DEPTH-entry circular buffer. Each entry is {pc, instr, is_ret, is_call, bp_taken, bp_target}. Registers: head and tail pointers (PTR_W bits, wrap modulo DEPTH) and count (PTR_W+1 bits, range 0..DEPTH).
- Reset (resetn low, asynchronous): head=0, tail=0, count=0. Hence out_valid=00 and queue_full=0. Entry storage need not be reset.
- queue_full = (count > DEPTH-2). Combinational from count only; no dependence on this cycle's pop.
- Read side, combinational from head:
  - out_valid[0] = count>=1; out_valid[1] = count>=2.
  - Invalid slots drive all-zero data.
  - Read latency: an entry written at edge N is visible on out_* after edge N.
- Pop:
  - effective pops = min(pop_cnt, count); pop_cnt=3 is treated as 2.
  - head advances by effective pops, modulo DEPTH.
- Push, ignored entirely when queue_full=1 or flush=1:
  - Valid slots are compacted in slot order and written at tail, tail+1.
  - push_valid=10 writes slot1 at tail. push_valid=11 writes slot0 at tail and slot1 at tail+1.
  - tail advances by popcount(push_valid).
- Simultaneous push and pop: next count = count + pushes - effective pops.
  - Pop acts on pre-edge contents; push uses pre-edge tail and queue_full.
  - A push into an empty queue is not bypassed to out_* in the same cycle.
- Flush: next head=tail=count=0; the same cycle's push and pop are discarded. Flush while reset is asserted: reset wins.
- Wrap-around: writes at tail=DEPTH-1 with two slots go to entries DEPTH-1 and 0. Pops wrap the same way.
- No overflow is possible: pushes are only accepted with at least 2 free entries. Underflow is prevented by the clamp.

Test Plan:
- Reset: assert resetn=0 mid-stream with count=5 -> immediately out_valid=00, queue_full=0; after release, push_valid=11 with PC 0xBFC00000/0xBFC00004 -> next cycle out_valid=11, out_pc={0xBFC00000,0xBFC00004}.
- Compaction: push_valid=10, pc[1]=0x80000004, bp_taken=1, bp_target=0x80000100 -> out_valid=01, out_pc[0]=0x80000004, out_bp_taken[0]=1, out_bp_target[0]=0x80000100.
- Fill/full: DEPTH=16, push 7 pairs with pop_cnt=0 -> count=14, queue_full=0. One more pair -> count=16, queue_full=1. Further push_valid=11 -> ignored, count stays 16. Pop 2 -> queue_full=0.
- Simultaneous: count=3, push_valid=11 with pop_cnt=2 -> count=3. The head becomes the old third entry, and the new pair is ordered after it.
- Wrap and clamp: 15 single pushes and pops leave head=tail=15. Push a pair -> entries land at 15 and 0 and read back in order. Then pop_cnt=2 with count=1 -> count=0, out_valid=00.
- Flush priority: count=6, flush=1 with push_valid=11 and pop_cnt=1 -> next cycle count=0, out_valid=00, queue_full=0. The following push lands at index 0.
